// File: rtl/mult_div_unit_pkg.sv
// Shared op/state encodings and op-decoding helpers for the iterative multiply/divide unit.
package mult_div_unit_pkg;

  typedef enum logic [1:0] {
    MD_OP_MULT  = 2'b00,
    MD_OP_MULTU = 2'b01,
    MD_OP_DIV   = 2'b10,
    MD_OP_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_DONE = 2'b10
  } md_state_t;

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/mult_div_unit_conditional_negate.sv
// Two's-complement negate-or-pass: out = neg ? -in : in.
module conditional_negate #(
  parameter int N = 32
) (
  input  logic [N-1:0] in,
  input  logic         neg,
  output logic [N-1:0] out
);

  assign out = neg ? (~in + {{(N-1){1'b0}}, 1'b1}) : in;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit (MULT, MULTU, DIV, DIVU) with HI/LO result registers.
// Optional MULTDIV_EARLY_OUT_EN: multiplies finish once the remaining multiplier magnitude is zero.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] inA,
  input  logic [N-1:0] inB,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  md_state_t state;
  logic           is_mul_reg, dz_reg, sign_q_reg, sign_r_reg;
  logic [CW-1:0]  cnt_reg;
  logic [2*N-1:0] mcand_reg, prod_reg;
  logic [N-1:0]   mplier_reg, rem_reg, quo_reg, divisor_reg;

  logic           in_signed, in_div, in_dz;
  logic [N-1:0]   a_mag, b_mag;
  logic [2*N-1:0] prod_next, prod_fix;
  logic [N-1:0]   mplier_next, rem_next, quo_next, rem_fix, quo_fix;
  logic [N:0]     shifted;
  logic           take, mul_last, last;

  assign in_signed = op_is_signed(op);
  assign in_div    = op_is_div(op);
  assign in_dz     = in_div && (inB == '0);

  // A zero-divisor op keeps the raw dividend in quo_reg so it can be committed to hi unchanged.
  conditional_negate #(.N(N)) u_neg_a (.in(inA), .neg(in_signed && inA[N-1] && !in_dz), .out(a_mag));
  conditional_negate #(.N(N)) u_neg_b (.in(inB), .neg(in_signed && inB[N-1]), .out(b_mag));

  assign prod_next   = prod_reg + (mplier_reg[0] ? mcand_reg : '0);
  assign mplier_next = mplier_reg >> 1;

  // Restoring division step on unsigned magnitudes; the partial remainder never reaches the divisor.
  assign shifted  = {rem_reg, quo_reg[N-1]};
  assign take     = shifted >= {1'b0, divisor_reg};
  assign rem_next = N'(take ? shifted - {1'b0, divisor_reg} : shifted);
  assign quo_next = {quo_reg[N-2:0], take};

  conditional_negate #(.N(2*N)) u_neg_p (.in(prod_next), .neg(sign_q_reg), .out(prod_fix));
  conditional_negate #(.N(N))   u_neg_q (.in(quo_next),  .neg(sign_q_reg), .out(quo_fix));
  conditional_negate #(.N(N))   u_neg_r (.in(rem_next),  .neg(sign_r_reg), .out(rem_fix));

`ifdef MULTDIV_EARLY_OUT_EN
  assign mul_last = (mplier_next == '0);
`else
  assign mul_last = (cnt_reg == LAST);
`endif

  assign last = dz_reg || (is_mul_reg ? mul_last : (cnt_reg == LAST));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= MD_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      is_mul_reg  <= 1'b0;
      dz_reg      <= 1'b0;
      sign_q_reg  <= 1'b0;
      sign_r_reg  <= 1'b0;
      cnt_reg     <= '0;
      mcand_reg   <= '0;
      prod_reg    <= '0;
      mplier_reg  <= '0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      divisor_reg <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      if (state == MD_RUN) begin
        cnt_reg    <= cnt_reg + 1'b1;
        prod_reg   <= prod_next;
        mcand_reg  <= mcand_reg << 1;
        mplier_reg <= mplier_next;
        rem_reg    <= rem_next;
        quo_reg    <= quo_next;
        if (last) begin
          state <= MD_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          if (dz_reg) begin
            hi          <= quo_reg;
            lo          <= '1;
            div_by_zero <= 1'b1;
          end else if (is_mul_reg) begin
            {hi, lo} <= prod_fix;
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
        end
      end else if (start) begin
        state       <= MD_RUN;
        busy        <= 1'b1;
        is_mul_reg  <= !in_div;
        dz_reg      <= in_dz;
        sign_q_reg  <= in_signed && (inA[N-1] ^ inB[N-1]);
        sign_r_reg  <= in_signed && in_div && inA[N-1];
        cnt_reg     <= '0;
        mcand_reg   <= {{N{1'b0}}, a_mag};
        prod_reg    <= '0;
        mplier_reg  <= b_mag;
        rem_reg     <= '0;
        quo_reg     <= a_mag;
        divisor_reg <= b_mag;
      end else begin
        state <= MD_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: random and directed ops checked against plain-arithmetic results.
// Latency expectations follow MULTDIV_EARLY_OUT_EN when the bench is built with it.
module tb_mult_div_unit;

  localparam int N = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op    = 2'b00;
  logic [N-1:0] inA   = '0;
  logic [N-1:0] inB   = '0;
  logic         busy, done, div_by_zero;
  logic [N-1:0] hi, lo;

  always #5 clock = ~clock;

  mult_div_unit #(.N(N)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .inA(inA), .inB(inB),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    logic [31:0] lat;
    logic [31:0] acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] p, q, r;
    logic [31:0] mag;
    int          bl;
    longint      sa, sb_v;
    e = '0;
    e.op = o; e.a = a; e.b = b;
    sa   = longint'($signed(a));
    sb_v = longint'($signed(b));
    if (o[1] == 1'b0) begin
      if (o == 2'b00) p = 64'(sa * sb_v);
      else            p = {32'b0, a} * {32'b0, b};
      e.hi = p[63:32];
      e.lo = p[31:0];
      mag  = (o == 2'b00 && b[31]) ? (32'd0 - b) : b;
      bl = 0;
      for (int i = 0; i < 32; i++) if (mag[i]) bl = i + 1;
`ifdef MULTDIV_EARLY_OUT_EN
      e.lat = (bl < 1) ? 32'd1 : 32'(bl);
`else
      e.lat = 32'd32;
`endif
    end else if (b == 32'd0) begin
      e.hi = a; e.lo = 32'hFFFF_FFFF; e.dz = 1'b1; e.lat = 32'd1;
    end else begin
      if (o == 2'b11) begin
        e.lo = a / b;
        e.hi = a % b;
      end else begin
        q = 64'(sa / sb_v);
        r = 64'(sa % sb_v);
        e.lo = q[31:0];
        e.hi = r[31:0];
      end
      e.lat = 32'd32;
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clock) begin
    if (reset && done) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 with no outstanding op, expected none (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        $display("op=%0d a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h dz=%0b latency=%0d",
                 mon_e.op, mon_e.a, mon_e.b, hi, lo, div_by_zero, cyc - int'(mon_e.acc));
        check("hi", 64'(hi), 64'(mon_e.hi));
        check("lo", 64'(lo), 64'(mon_e.lo));
        check("div_by_zero", 64'(div_by_zero), 64'(mon_e.dz));
        check("busy_at_done", 64'(busy), 64'd0);
        check("latency", 64'(cyc - int'(mon_e.acc)), 64'(mon_e.lat));
      end
    end
  end

  // Called at a negedge; waits for the unit to be idle or in its done cycle, then starts one op.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   guard = 0;
    while (busy && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout: got busy=1 after %0d cycles, expected 0", guard);
    end
    op = o; inA = a; inB = b; start = 1'b1;
    e = model(o, a, b);
    e.acc = 32'(cyc + 1);
    sb.push_back(e);
    @(negedge clock);
    start = 1'b0;
    check("busy_after_accept", 64'(busy), 64'd1);
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((busy || sb.size() != 0) && guard < 500) begin
      @(negedge clock);
      guard++;
    end
    if (busy || sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d outstanding ops, expected 0", sb.size());
    end
    @(negedge clock);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    int          sel;

    repeat (2) @(negedge clock);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_dz", 64'(div_by_zero), 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    reset = 1'b1;
    @(negedge clock);

    // Directed vectors, issued back to back through the done cycle.
    issue(2'b00, 32'hFFFF_FFFD, 32'd7);
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(2'b11, 32'd100, 32'd7);
    issue(2'b11, 32'd5, 32'd0);
    issue(2'b01, 32'd2, 32'd3);
    issue(2'b01, 32'd9, 32'd5);
    issue(2'b10, 32'h8000_0000, 32'd0);
    wait_idle();

    // Stray start pulse while running must be ignored.
    issue(2'b00, 32'h1234_5678, 32'h8765_4321);
    repeat (4) @(negedge clock);
    op = 2'b11; inA = $urandom; inB = $urandom; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_idle();

    // Reset in the middle of a run clears everything and the aborted op never completes.
    issue(2'b00, 32'hFFFF_FFFD, 32'd7);
    wait_idle();
    issue(2'b01, 32'h1234_5678, 32'h9ABC_DEF1);
    repeat (9) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("midrun_reset_busy", 64'(busy), 64'd0);
    check("midrun_reset_done", 64'(done), 64'd0);
    check("midrun_reset_hi", 64'(hi), 64'd0);
    check("midrun_reset_lo", 64'(lo), 64'd0);
    sb.delete();
    @(negedge clock);
    reset = 1'b1;
    repeat (40) @(negedge clock);
    check("post_reset_hi", 64'(hi), 64'd0);

    // Random mix including zero divisors, small multipliers and MIN/-1.
    for (int i = 0; i < 150; i++) begin
      ro  = 2'($urandom_range(0, 3));
      ra  = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(0, 15));
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3:       rb = 32'h8000_0000;
        default: rb = $urandom;
      endcase
      issue(ro, ra, rb);
      if ($urandom_range(0, 3) == 0) begin
        wait_idle();
        repeat ($urandom_range(0, 2)) @(negedge clock);
      end
    end
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
